// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino game obstacle logic.
package dino_pkg;

  localparam int DEFAULT_MIN_GAP = 20;
  localparam int DEFAULT_GAP_W   = 6;

  typedef enum logic [1:0] {
    KIND_SMALL_CACTUS = 2'b00,
    KIND_LARGE_CACTUS = 2'b01,
    KIND_CACTUS_GROUP = 2'b10,
    KIND_BIRD         = 2'b11
  } obstacle_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADV,
    ST_LOAD,
    ST_WAIT,
    ST_OFFER
  } sched_state_e;

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Spawn handshake bundle between the obstacle scheduler and its consumer;
// the parent binds these signals to the scheduler's spawn_* ports.
interface obstacle_scheduler_if;

  logic       valid;
  logic       ready;
  logic [1:0] kind;
  logic [1:0] height;

  modport master (output valid, output kind, output height, input ready);
  modport slave  (input valid, input kind, input height, output ready);

endinterface

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: draws a random gap and obstacle kind from an external LFSR,
// counts video frames, then offers the spawn with a valid/ready handshake.
// Optional macro OBSTACLE_BIRD_EN enables bird obstacles (kind 11 with a height index).
module obstacle_scheduler
  import dino_pkg::*;
#(
  parameter int MIN_GAP = DEFAULT_MIN_GAP,
  parameter int GAP_W   = DEFAULT_GAP_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        frame_i,
  input  logic [1:0]  speed_lvl_i,
  input  logic [15:0] rand_i,
  output logic        next_o,
  output logic        spawn_valid_o,
  input  logic        spawn_ready_i,
  output logic [1:0]  spawn_kind_o,
  output logic [1:0]  spawn_height_o,
  output logic [7:0]  spawn_count_o
);

  sched_state_e   state, state_next;
  logic [7:0]     gap_cnt;
  logic [7:0]     rand_gap;
  logic [7:0]     load_gap;
  obstacle_kind_e raw_kind;
  obstacle_kind_e kind_d, kind_q;
  logic [1:0]     height_d, height_q;
  logic           accept;
  logic           unused_rand;

  // Bits of rand_i above the gap field and below the kind field are intentionally unused.
  assign unused_rand = ^rand_i;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (!enable_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_ADV;
        ST_ADV:   state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_WAIT;
        ST_WAIT:  if (frame_i && gap_cnt == 8'd1) state_next = ST_OFFER;
        ST_OFFER: if (spawn_ready_i) state_next = ST_ADV;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  assign next_o        = (state == ST_ADV);
  assign spawn_valid_o = (state == ST_OFFER);
  assign accept        = spawn_valid_o && spawn_ready_i;

  // Random part of the gap shrinks with difficulty; max MIN_GAP(192) + 63 fits in 8 bits.
  assign rand_gap = 8'(rand_i[GAP_W-1:0]) >> speed_lvl_i;
  assign load_gap = 8'(MIN_GAP) + rand_gap;

  always_comb begin
    raw_kind = obstacle_kind_e'(rand_i[15:14]);
`ifdef OBSTACLE_BIRD_EN
    kind_d   = raw_kind;
    height_d = rand_i[13:12];
`else
    kind_d   = (raw_kind == KIND_BIRD) ? KIND_CACTUS_GROUP : raw_kind;
    height_d = 2'b00;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gap_cnt       <= 8'd0;
      kind_q        <= KIND_SMALL_CACTUS;
      height_q      <= 2'b00;
      spawn_count_o <= 8'd0;
    end else begin
      if (state == ST_LOAD) begin
        gap_cnt  <= load_gap;
        kind_q   <= kind_d;
        height_q <= height_d;
      end else if (state == ST_WAIT && frame_i) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      if (accept && spawn_count_o != 8'hFF) spawn_count_o <= spawn_count_o + 8'd1;
    end
  end

  assign spawn_kind_o   = kind_q;
  assign spawn_height_o = height_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler: reset, gap timing, difficulty,
// backpressure, kind mapping and disable/re-enable behaviour.
module tb_obstacle_scheduler;
  import dino_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        frame;
  logic [1:0]  speed;
  logic [15:0] rand_v;
  logic        next;
  logic [7:0]  count;

  int checks = 0;
  int errors = 0;

  obstacle_scheduler_if spawn_bus ();

  obstacle_scheduler #(.MIN_GAP(20), .GAP_W(6)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .frame_i        (frame),
    .speed_lvl_i    (speed),
    .rand_i         (rand_v),
    .next_o         (next),
    .spawn_valid_o  (spawn_bus.valid),
    .spawn_ready_i  (spawn_bus.ready),
    .spawn_kind_o   (spawn_bus.kind),
    .spawn_height_o (spawn_bus.height),
    .spawn_count_o  (count)
  );

  always #5 clk = ~clk;

`ifdef OBSTACLE_BIRD_EN
  localparam logic [1:0] EXP_F_KIND   = 2'b11;
  localparam logic [1:0] EXP_F_HEIGHT = 2'b11;
`else
  localparam logic [1:0] EXP_F_KIND   = 2'b10;
  localparam logic [1:0] EXP_F_HEIGHT = 2'b00;
`endif

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses frame every other cycle until valid rises; returns the number of frames (0 on timeout).
  task automatic frames_until_valid(output int n);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      if (spawn_bus.valid) begin
        n = i;
        break;
      end
      tick();
    end
  endtask

  int n;
  int pulses;
  logic [1:0] held_kind;

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    frame = 1'b0;
    speed = 2'd0;
    rand_v = 16'h0000;
    spawn_bus.ready = 1'b0;
    #1;
    check("reset_next",  16'(next), 16'h0);
    check("reset_valid", 16'(spawn_bus.valid), 16'h0);
    check("reset_count", 16'(count), 16'h0);
    tick();
    tick();
    rst = 1'b0;

    // Gap scenario: rand 0005, speed 0 -> 25 frames; frames during ADV/LOAD are ignored.
    rand_v = 16'h0005;
    enable = 1'b1;
    frame = 1'b1;
    tick();
    check("adv_next_pulse", 16'(next), 16'h1);
    tick();
    check("load_next_low", 16'(next), 16'h0);
    tick();
    frame = 1'b0;
    check("wait_valid_low", 16'(spawn_bus.valid), 16'h0);
    frames_until_valid(n);
    check("gap_25_frames", 16'(n), 16'd25);
    check("gap_kind", 16'(spawn_bus.kind), 16'h0);
    check("gap_height", 16'(spawn_bus.height), 16'h0);

    // Backpressure: 10 cycles without ready, frames pulsing.
    for (int i = 0; i < 10; i++) begin
      frame = i[0];
      tick();
      check("bp_valid", 16'(spawn_bus.valid), 16'h1);
      check("bp_next", 16'(next), 16'h0);
      check("bp_kind", 16'(spawn_bus.kind), 16'h0);
      check("bp_count", 16'(count), 16'h0);
    end
    frame = 1'b0;
    spawn_bus.ready = 1'b1;
    tick();
    spawn_bus.ready = 1'b0;
    check("accept_count", 16'(count), 16'h1);
    check("accept_valid_low", 16'(spawn_bus.valid), 16'h0);
    check("accept_next_pulse", 16'(next), 16'h1);

    // Difficulty: rand 003F, speed 2 -> 20 + 15 = 35 frames; ready while not valid is ignored.
    rand_v = 16'h003F;
    speed = 2'd2;
    spawn_bus.ready = 1'b1;
    tick();
    check("next_one_cycle", 16'(next), 16'h0);
    tick();
    tick();
    check("ready_ignored_count", 16'(count), 16'h1);
    spawn_bus.ready = 1'b0;
    frames_until_valid(n);
    check("difficulty_35_frames", 16'(n), 16'd35);
    spawn_bus.ready = 1'b1;
    tick();
    spawn_bus.ready = 1'b0;
    check("accept2_count", 16'(count), 16'h2);

    // Kind scenario: rand F000 at LOAD, speed 0 -> gap 20.
    rand_v = 16'hF000;
    speed = 2'd0;
    tick();
    tick();
    frames_until_valid(n);
    check("kind_gap_20", 16'(n), 16'd20);
    check("kind_f000", 16'(spawn_bus.kind), 16'(EXP_F_KIND));
    check("height_f000", 16'(spawn_bus.height), 16'(EXP_F_HEIGHT));
    held_kind = spawn_bus.kind;

    // Disable during OFFER: retract without counting, then re-enable.
    enable = 1'b0;
    tick();
    check("disable_valid", 16'(spawn_bus.valid), 16'h0);
    check("disable_count", 16'(count), 16'h2);
    tick();
    check("disabled_next", 16'(next), 16'h0);
    check("disabled_count_hold", 16'(count), 16'h2);
    enable = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (next) pulses++;
    end
    check("reenable_one_next", 16'(pulses), 16'd1);
    check("reenable_kind", 16'(spawn_bus.kind), 16'(held_kind));

    // Reset mid-WAIT: outputs clear immediately, no clock edge needed.
    frame = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_next", 16'(next), 16'h0);
    check("rst_valid", 16'(spawn_bus.valid), 16'h0);
    check("rst_kind", 16'(spawn_bus.kind), 16'h0);
    check("rst_height", 16'(spawn_bus.height), 16'h0);
    check("rst_count", 16'(count), 16'h0);
    tick();
    check("rst_held_next", 16'(next), 16'h0);
    frame = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_adv", 16'(next), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
